// File: rtl/cu_pkg.sv
// Shared encodings for the control sequencer: FSM states, instruction
// classes, condition codes and the per-state strobe decode.
package cu_pkg;

  typedef enum logic [3:0] {
    RST    = 4'd0,
    F_ADDR = 4'd1,
    F_WAIT = 4'd2,
    DECODE = 4'd3,
    EX_DP  = 4'd4,
    M_ADDR = 4'd5,
    M_WAIT = 4'd6,
    M_WB   = 4'd7,
    LINK   = 4'd8,
    BR     = 4'd9,
    FAULT  = 4'd15
  } state_e;

  localparam logic [2:0] OP_DP    = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_B     = 3'd3;
  localparam logic [2:0] OP_BL    = 3'd4;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  typedef struct packed {
    logic pc_ld;
    logic mar_ld;
    logic mdr_ld;
    logic rf_ld;
    logic fr_ld;
    logic pc_sel;
    logic link_sel;
    logic mov;
    logic rw;
    logic fault;
  } ctl_t;

  // Moore strobe set for a state; class and S bit come from the held IR.
  function automatic ctl_t state_ctl(input state_e st, input logic is_load,
                                     input logic is_store, input logic s_bit);
    ctl_t c;
    c = '0;
    case (st)
      F_ADDR: begin
        c.mar_ld = 1'b1;
        c.pc_ld  = 1'b1;
      end
      F_WAIT: begin
        c.mov = 1'b1;
        c.rw  = 1'b1;
      end
      EX_DP: begin
        c.rf_ld = 1'b1;
        c.fr_ld = s_bit;
      end
      M_ADDR: begin
        c.mar_ld = 1'b1;
        c.mdr_ld = is_store;
      end
      M_WAIT: begin
        c.mov = 1'b1;
        c.rw  = is_load;
      end
      M_WB: c.rf_ld = 1'b1;
      LINK: begin
        c.rf_ld    = 1'b1;
        c.link_sel = 1'b1;
      end
      BR: begin
        c.pc_ld  = 1'b1;
        c.pc_sel = 1'b1;
      end
      FAULT: c.fault = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational evaluation of the 4-bit condition field against NZCV.
module cond_eval
  import cu_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic       N,
  input  logic       Z,
  input  logic       C,
  input  logic       V,
  output logic       Cond_True
);

  always_comb begin
    Cond_True = 1'b0;
    case (Cond)
      COND_EQ: Cond_True = Z;
      COND_NE: Cond_True = !Z;
      COND_CS: Cond_True = C;
      COND_CC: Cond_True = !C;
      COND_MI: Cond_True = N;
      COND_PL: Cond_True = !N;
      COND_VS: Cond_True = V;
      COND_VC: Cond_True = !V;
      COND_HI: Cond_True = C && !Z;
      COND_LS: Cond_True = !C || Z;
      COND_GE: Cond_True = (N == V);
      COND_LT: Cond_True = (N != V);
      COND_GT: Cond_True = !Z && (N == V);
      COND_LE: Cond_True = Z || (N != V);
      COND_AL: Cond_True = 1'b1;
      COND_NV: Cond_True = 1'b0;
      default: Cond_True = 1'b0;
    endcase
  end

endmodule

// File: rtl/cu_sequencer.sv
// Multi-cycle control sequencer: fetch, decode/condition check, execute,
// memory handshake with timeout, writeback.
module cu_sequencer
  import cu_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned CNT_W      = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [2:0] Op_Class,
  input  logic [3:0] Cond,
  input  logic       S_bit,
  input  logic       N,
  input  logic       Z,
  input  logic       C,
  input  logic       V,
  input  logic       MOC,
  output logic       PC_Ld,
  output logic       IR_Ld,
  output logic       MAR_Ld,
  output logic       MDR_Ld,
  output logic       RF_Ld,
  output logic       FR_Ld,
  output logic       PC_Sel,
  output logic       Link_Sel,
  output logic       MOV,
  output logic       RW,
  output logic       Fault,
  output logic [3:0] State
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctl_t             ctl_q, ctl_d;
  logic             cond_true;
  logic             is_load;
  logic             is_store;
  logic             wait_expired;

  cond_eval u_cond_eval (
    .Cond      (Cond),
    .N         (N),
    .Z         (Z),
    .C         (C),
    .V         (V),
    .Cond_True (cond_true)
  );

  assign is_load      = (Op_Class == OP_LOAD);
  assign is_store     = (Op_Class == OP_STORE);
  // Last permitted wait cycle: without MOC here the handshake has timed out.
  assign wait_expired = (cnt_q == CNT_W'(WAIT_LIMIT - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RST: state_d = F_ADDR;
      F_ADDR: begin
        state_d = F_WAIT;
        cnt_d   = '0;
      end
      F_WAIT: begin
        if (MOC) begin
          state_d = DECODE;
        end else if (wait_expired) begin
          state_d = FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DECODE: begin
        if (!cond_true) begin
          state_d = F_ADDR;
        end else begin
          case (Op_Class)
            OP_DP:             state_d = EX_DP;
            OP_LOAD, OP_STORE: state_d = M_ADDR;
            OP_B:              state_d = BR;
            OP_BL:             state_d = LINK;
            default:           state_d = F_ADDR;
          endcase
        end
      end
      EX_DP: state_d = F_ADDR;
      M_ADDR: begin
        state_d = M_WAIT;
        cnt_d   = '0;
      end
      M_WAIT: begin
        if (MOC) begin
          state_d = is_load ? M_WB : F_ADDR;
        end else if (wait_expired) begin
          state_d = FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      M_WB:    state_d = F_ADDR;
      LINK:    state_d = BR;
      BR:      state_d = F_ADDR;
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase
  end

  // Strobes are decoded from the next state so they are flops aligned with state_q.
  assign ctl_d = state_ctl(state_d, is_load, is_store, S_bit);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= RST;
      cnt_q   <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
    end
  end

  // IR_Ld and the load-side MDR_Ld must react to MOC within the same cycle.
  assign IR_Ld    = (state_q == F_WAIT) && MOC;
  assign MDR_Ld   = ctl_q.mdr_ld || ((state_q == M_WAIT) && is_load && MOC);
  assign PC_Ld    = ctl_q.pc_ld;
  assign MAR_Ld   = ctl_q.mar_ld;
  assign RF_Ld    = ctl_q.rf_ld;
  assign FR_Ld    = ctl_q.fr_ld;
  assign PC_Sel   = ctl_q.pc_sel;
  assign Link_Sel = ctl_q.link_sel;
  assign MOV      = ctl_q.mov;
  assign RW       = ctl_q.rw;
  assign Fault    = ctl_q.fault;
  assign State    = state_q;

endmodule

// File: tb/tb_cu_sequencer.sv
// Self-checking bench for cu_sequencer: an instruction-level model expands
// each instruction into its expected per-cycle trace, checked every cycle.
module tb_cu_sequencer;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [2:0] Op_Class;
  logic [3:0] Cond;
  logic       S_bit, N, Z, C, V, MOC;
  logic       PC_Ld, IR_Ld, MAR_Ld, MDR_Ld, RF_Ld, FR_Ld;
  logic       PC_Sel, Link_Sel, MOV, RW, Fault;
  logic [3:0] State;

  always #5 Clk = ~Clk;

  cu_sequencer #(.WAIT_LIMIT(15), .CNT_W(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Op_Class(Op_Class), .Cond(Cond),
    .S_bit(S_bit), .N(N), .Z(Z), .C(C), .V(V), .MOC(MOC),
    .PC_Ld(PC_Ld), .IR_Ld(IR_Ld), .MAR_Ld(MAR_Ld), .MDR_Ld(MDR_Ld),
    .RF_Ld(RF_Ld), .FR_Ld(FR_Ld), .PC_Sel(PC_Sel), .Link_Sel(Link_Sel),
    .MOV(MOV), .RW(RW), .Fault(Fault), .State(State)
  );

  localparam int LIMIT = 15;

  // Output vector bit masks, order {PC,IR,MAR,MDR,RF,FR,PCS,LNK,MOV,RW,FLT}.
  localparam logic [10:0] PCL  = 11'h400, IRL  = 11'h200, MARL = 11'h100;
  localparam logic [10:0] MDRL = 11'h080, RFL  = 11'h040, FRL  = 11'h020;
  localparam logic [10:0] PCS  = 11'h010, LNK  = 11'h008, MOVB = 11'h004;
  localparam logic [10:0] RWB  = 11'h002, FLT  = 11'h001, NONE = 11'h000;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  cond;
    logic        s;
    logic [3:0]  nzcv;
    logic        moc;
    logic [3:0]  st;
    logic [10:0] outs;
  } cyc_t;

  cyc_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   fr_seen, rf_seen;

  logic [2:0] cur_op;
  logic [3:0] cur_cond, cur_nzcv;
  logic       cur_s, idle_moc;

  wire [10:0] obs = {PC_Ld, IR_Ld, MAR_Ld, MDR_Ld, RF_Ld, FR_Ld,
                     PC_Sel, Link_Sel, MOV, RW, Fault};

  // Conditions come in complementary pairs: bit 0 inverts the base test.
  function automatic logic cond_model(input logic [3:0] cd, input logic [3:0] f);
    logic n, z, c, v, base;
    {n, z, c, v} = f;
    case (cd[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return base ^ cd[0];
  endfunction

  task automatic push(input logic [3:0] st, input logic [10:0] outs, input logic moc);
    cyc_t e;
    e.op = cur_op; e.cond = cur_cond; e.s = cur_s; e.nzcv = cur_nzcv;
    e.moc = moc; e.st = st; e.outs = outs;
    exp_q.push_back(e);
  endtask

  task automatic begin_trace(input logic moc_idle);
    exp_q.delete();
    idle_moc = moc_idle;
    cur_op = 3'd7; cur_cond = 4'h0; cur_s = 1'b0; cur_nzcv = 4'h0;
    push(4'd0, NONE, idle_moc);
  endtask

  // mdly < 0 means MOC never arrives for the data access.
  task automatic add_instr(input logic [2:0] op, input logic [3:0] cd, input logic s,
                           input logic [3:0] f, input int fdly, input int mdly);
    int waits;
    cur_op = op; cur_cond = cd; cur_s = s; cur_nzcv = f;
    push(4'd1, PCL | MARL, idle_moc);
    for (int i = 0; i < fdly; i++) push(4'd2, MOVB | RWB, 1'b0);
    push(4'd2, MOVB | RWB | IRL, 1'b1);
    push(4'd3, NONE, idle_moc);
    if (!cond_model(cd, f) || op > 3'd4) return;
    waits = (mdly < 0) ? LIMIT : mdly;
    case (op)
      3'd0: push(4'd4, RFL | (s ? FRL : NONE), idle_moc);
      3'd1, 3'd2: begin
        push(4'd5, (op == 3'd2) ? (MARL | MDRL) : MARL, idle_moc);
        for (int i = 0; i < waits; i++)
          push(4'd6, (op == 3'd1) ? (MOVB | RWB) : MOVB, 1'b0);
        if (mdly < 0) begin
          for (int i = 0; i < 4; i++) push(4'd15, FLT, idle_moc);
        end else if (op == 3'd1) begin
          push(4'd6, MOVB | RWB | MDRL, 1'b1);
          push(4'd7, RFL, idle_moc);
        end else begin
          push(4'd6, MOVB, 1'b1);
        end
      end
      3'd3: push(4'd9, PCL | PCS, idle_moc);
      default: begin
        push(4'd8, RFL | LNK, idle_moc);
        push(4'd9, PCL | PCS, idle_moc);
      end
    endcase
  endtask

  task automatic check1(input string nm, input int idx, input logic [10:0] got,
                        input logic [10:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s[%0d]: got 0x%03h want 0x%03h", nm, idx, got, want);
    end
  endtask

  task automatic run_trace(input string nm);
    cyc_t e;
    int   idx;
    fr_seen = 0; rf_seen = 0; idx = 0;
    Reset_n = 1'b0;
    MOC = 1'b0; Op_Class = 3'd7; Cond = 4'h0; S_bit = 1'b0; {N, Z, C, V} = 4'h0;
    @(posedge Clk); @(posedge Clk); #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (idx > 0) begin
        @(posedge Clk); #1;
      end else begin
        Reset_n = 1'b1;
      end
      Op_Class = e.op; Cond = e.cond; S_bit = e.s; {N, Z, C, V} = e.nzcv; MOC = e.moc;
      #3;
      check1({nm, ".state"}, idx, {7'd0, State}, {7'd0, e.st});
      check1({nm, ".outs"}, idx, obs, e.outs);
      fr_seen += int'(FR_Ld);
      rf_seen += int'(RF_Ld);
      idx++;
    end
  endtask

  initial begin
    Reset_n = 1'b0;
    MOC = 1'b0; Op_Class = 3'd0; Cond = 4'h0; S_bit = 1'b0; {N, Z, C, V} = 4'h0;

    // Pin the condition model to hand-computed truth values.
    check1("model_hi", 0, {10'd0, cond_model(4'h8, 4'b0010)}, 11'd1);
    check1("model_ls", 0, {10'd0, cond_model(4'h9, 4'b0010)}, 11'd0);
    check1("model_le", 0, {10'd0, cond_model(4'hD, 4'b1000)}, 11'd1);
    check1("model_gt", 0, {10'd0, cond_model(4'hC, 4'b1001)}, 11'd1);
    check1("model_nv", 0, {10'd0, cond_model(4'hF, 4'b1111)}, 11'd0);

    // DP, AL, S=1, MOC tied high: states 0,1,2,3,4,1.
    begin_trace(1'b1);
    add_instr(3'd0, 4'hE, 1'b1, 4'h0, 0, 0);
    cur_op = 3'd7;
    push(4'd1, PCL | MARL, 1'b1);
    run_trace("dp_s1");
    check1("dp_s1.fr_count", 0, 11'(fr_seen), 11'd1);
    check1("dp_s1.rf_count", 0, 11'(rf_seen), 11'd1);

    begin_trace(1'b1);
    add_instr(3'd0, 4'hE, 1'b0, 4'h0, 0, 0);
    push(4'd1, PCL | MARL, 1'b1);
    run_trace("dp_s0");
    check1("dp_s0.fr_count", 0, 11'(fr_seen), 11'd0);
    check1("dp_s0.rf_count", 0, 11'(rf_seen), 11'd1);

    // B EQ: Z=0 annulled, Z=1 taken.
    begin_trace(1'b0);
    add_instr(3'd3, 4'h0, 1'b0, 4'b0000, 0, 0);
    add_instr(3'd3, 4'h0, 1'b0, 4'b0100, 0, 0);
    push(4'd1, PCL | MARL, 1'b0);
    run_trace("b_eq");

    // Every condition code against every flag combination.
    begin_trace(1'b0);
    for (int unsigned c = 0; c < 16; c++)
      for (int unsigned f = 0; f < 16; f++) begin
        idle_moc = f[0];
        add_instr(((c + f) % 2 == 1) ? 3'd3 : 3'd0, 4'(c), 1'b1, 4'(f), 0, 0);
      end
    run_trace("sweep");

    // Mixed memory traffic, links, NOP classes and wait-count boundaries.
    begin_trace(1'b1);
    add_instr(3'd1, 4'hE, 1'b0, 4'h0, 0, 3);
    add_instr(3'd2, 4'hE, 1'b1, 4'h0, 1, 2);
    add_instr(3'd4, 4'hE, 1'b0, 4'h0, 0, 0);
    add_instr(3'd5, 4'hE, 1'b1, 4'h0, 0, 0);
    add_instr(3'd6, 4'hE, 1'b1, 4'h0, 0, 0);
    add_instr(3'd7, 4'hE, 1'b1, 4'h0, 0, 0);
    add_instr(3'd1, 4'hE, 1'b0, 4'h0, 0, 14);
    add_instr(3'd0, 4'hE, 1'b1, 4'h0, 14, 0);
    add_instr(3'd0, 4'hF, 1'b1, 4'h0, 0, 0);
    add_instr(3'd2, 4'hE, 1'b0, 4'h0, 0, 0);
    add_instr(3'd2, 4'h1, 1'b1, 4'b0100, 0, 0);
    push(4'd1, PCL | MARL, 1'b1);
    run_trace("mixed");
    check1("mixed.fr_count", 0, 11'(fr_seen), 11'd1);

    // STORE whose MOC never comes: timeout, then asynchronous reset.
    begin_trace(1'b0);
    add_instr(3'd2, 4'hE, 1'b0, 4'h0, 0, -1);
    run_trace("timeout");
    Reset_n = 1'b0;
    #1;
    check1("fault_reset.state", 0, {7'd0, State}, 11'd0);
    check1("fault_reset.fault", 0, {10'd0, Fault}, 11'd0);

    // Reset in the middle of a fetch handshake drops MOV at once.
    begin_trace(1'b0);
    cur_op = 3'd0; cur_cond = 4'hE;
    push(4'd1, PCL | MARL, 1'b0);
    for (int i = 0; i < 3; i++) push(4'd2, MOVB | RWB, 1'b0);
    run_trace("midfetch");
    Reset_n = 1'b0;
    #1;
    check1("midfetch_reset.mov", 0, {10'd0, MOV}, 11'd0);
    check1("midfetch_reset.state", 0, {7'd0, State}, 11'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cu_sequencer.md
Name: cu_sequencer

Overview:
- Multi-cycle control sequencer for the RISC core datapath.
- Steps each instruction through fetch, decode/condition check, execute, memory and writeback.
- Generates the load strobes for PC, IR, MAR, MDR, the register file and the NZCV flag register (FR_Ld).
- Evaluates the 4-bit condition field against the registered flags, and runs the memory MOV/MOC handshake with a timeout.

Parameters:
WAIT_LIMIT, 15, max cycles MOV stays asserted without MOC before entering FAULT
CNT_W, 4, width of wait counter; must hold WAIT_LIMIT

Ports:
Clk  in  1  rising-edge clock
Reset_n  in  1  asynchronous, active-low reset
Op_Class  in  3  decoded class: 0 DP, 1 LOAD, 2 STORE, 3 B, 4 BL, 5-7 NOP
Cond  in  4  instruction condition field
S_bit  in  1  DP instruction updates flags
N, Z, C, V  in  1 each  current flag register outputs
MOC  in  1  memory operation complete
PC_Ld, IR_Ld, MAR_Ld, MDR_Ld, RF_Ld, FR_Ld  out  1 each  datapath load strobes
PC_Sel  out  1  0 = PC+4, 1 = branch target
Link_Sel  out  1  RF write address forced to R14, data = PC
MOV  out  1  memory operation valid
RW  out  1  1 = read, 0 = write
Fault  out  1  sticky memory-timeout indicator
State  out  4  current state encoding, for debug

Behaviour:
- Reset_n low forces state RST and clears the wait counter, asynchronously.
- All outputs are Moore-decoded from the state; every output is 0 in RST.
- RST -> F_ADDR unconditionally on the first clock edge after release.
- F_ADDR: MAR_Ld=1, PC_Ld=1, PC_Sel=0. Next state F_WAIT.
- F_WAIT: MOV=1, RW=1. When MOC=1, IR_Ld=1 (Mealy qualified by MOC) and next state is DECODE; otherwise stay.
- DECODE: evaluate the condition on the N, Z, C, V inputs.
  - Codes: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - Codes: 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0.
  - Condition false, or Op_Class 5-7 -> F_ADDR (instruction annulled, no strobes).
  - Otherwise dispatch: DP -> EX_DP; LOAD and STORE -> M_ADDR; B -> BR; BL -> LINK.
- EX_DP: RF_Ld=1, FR_Ld=S_bit. Next state F_ADDR.
  - FR_Ld is asserted in this state only; it is never asserted by annulled instructions, memory ops or branches.
- M_ADDR: MAR_Ld=1; MDR_Ld=1 for STORE. Next state M_WAIT.
- M_WAIT: MOV=1, RW=1 for LOAD and 0 for STORE.
  - On MOC: LOAD asserts MDR_Ld and goes to M_WB; STORE goes to F_ADDR.
- M_WB: RF_Ld=1. Next state F_ADDR.
- LINK: RF_Ld=1, Link_Sel=1. Next state BR.
- BR: PC_Ld=1, PC_Sel=1. Next state F_ADDR.
- Op_Class, Cond and S_bit are stable from DECODE until the instruction retires; they are sourced from the IR.
- Wait counter:
  - Cleared on entry to F_WAIT or M_WAIT.
  - Increments each cycle in those states while MOC=0.
  - If the counter reaches WAIT_LIMIT with MOC=0 -> FAULT.
  - MOC=1 in the same cycle the counter reaches WAIT_LIMIT counts as success; MOC wins.
- FAULT: Fault=1, all strobes and MOV 0. The only exit is reset.
- MOC outside the wait states is ignored.
- Reset mid-handshake drops MOV immediately, asynchronously.
- Fetch latency with zero-wait memory (MOC high on the first F_WAIT cycle): F_ADDR, F_WAIT, DECODE = 3 cycles.
- Total instruction cycles: DP 4, B 4, BL 5, STORE 5, LOAD 6.

Decomposition:
- Package cu_pkg holds:
  - state encoding constants: RST=0, F_ADDR=1, F_WAIT=2, DECODE=3, EX_DP=4, M_ADDR=5, M_WAIT=6, M_WB=7, LINK=8, BR=9, FAULT=15;
  - Op_Class constants;
  - condition code constants.
- One sub-module, cond_eval: purely combinational. Inputs are Cond, N, Z, C, V; output is Cond_True.
- The state register, counter and output decode stay in cu_sequencer.

Test Plan:
- Reset release with MOC tied 1, Op_Class=0, Cond=E, S_bit=1 -> states 0,1,2,3,4,1. FR_Ld=1 for exactly one cycle, in EX_DP. RF_Ld=1 in the same cycle.
- Same setup but S_bit=0 -> RF_Ld pulses and FR_Ld stays 0 for the whole run.
- Op_Class=3, Cond=0 (EQ): with Z=0 -> DECODE goes to F_ADDR, no PC_Sel=1 pulse. With Z=1 -> BR with PC_Ld=1 and PC_Sel=1.
- Sweep all 16 Cond values across all 16 NZCV combinations in DECODE -> dispatch exactly matches the truth table; NV never dispatches.
- LOAD with MOC delayed 3 cycles -> MOV=1, RW=1 held for 4 cycles in M_WAIT, then MDR_Ld pulses. M_WB then asserts RF_Ld.
- STORE with MOC held at 0 -> Fault rises after 15 wait cycles, MOV drops, state 15 held. Asserting Reset_n=0 mid-FAULT -> State=0 and Fault=0 immediately, without waiting for a clock.
